round_robin_arbiter: RTL and testbench

- Parameterised N-way round-robin arbiter.
- Produces a one-hot, combinational grant from a request vector.
- Rotates priority so the most recently granted requester becomes lowest priority.
- Used by interconnect sockets (TileLink B/D channel muxes) to pick which device link owns the host channel; the socket holds `enable` low while a multi-beat message is in flight.

---
 rtl/round_robin_arbiter.sv | 51 +++++
 tb/tb_round_robin_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, rotating priority pointer.
// Optional simulation assertions are compiled in when RR_ARBITER_ASSERT_EN is defined.
module round_robin_arbiter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] request,
  output logic [WIDTH-1:0] grant
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAST_RST = ONE << (WIDTH - 1);

  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] upper_mask;
  logic [WIDTH-1:0] req_upper;
  logic [WIDTH-1:0] pick;

  // Thermometer mask of positions strictly above last; if none of them request,
  // wrap to the lowest set request bit. x & -x isolates the lowest set bit.
  always_comb begin
    upper_mask = ~(last | (last - ONE));
    req_upper  = request & upper_mask;
    if (req_upper != '0) begin
      pick = req_upper & (~req_upper + ONE);
    end else begin
      pick = request & (~request + ONE);
    end
    grant = enable ? pick : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= LAST_RST;
    end else if (enable && (grant != '0)) begin
      last <= grant;
    end
  end

`ifdef RR_ARBITER_ASSERT_EN
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_grant_subset  : assert property (@(posedge clk) disable iff (rst) (grant & ~request) == '0);
  a_disable_zero  : assert property (@(posedge clk) disable iff (rst) !enable |-> grant == '0);
  a_work_conserve : assert property (@(posedge clk) disable iff (rst)
                                     (enable && request != '0) |-> grant != '0);
  a_last_onehot   : assert property (@(posedge clk) disable iff (rst) $onehot(last));
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: vector table, random model run and a WIDTH=1 instance.
module tb_round_robin_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] request;
  logic [W-1:0] grant;

  logic         rst1;
  logic         en1;
  logic [0:0]   req1;
  logic [0:0]   grant1;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] req;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  round_robin_arbiter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .request(request),
    .grant  (grant)
  );

  round_robin_arbiter #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst    (rst1),
    .enable (en1),
    .request(req1),
    .grant  (grant1)
  );

  always #5 clk = ~clk;

  function automatic void add_vec(input logic r, input logic e, input logic [W-1:0] q,
                                  input logic [W-1:0] ex);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.exp = ex;
    vecs.push_back(v);
  endfunction

  // Independent reference: scan upward from the pointer index, wrapping.
  function automatic logic [W-1:0] model_grant(input int unsigned li, input logic e,
                                               input logic [W-1:0] q);
    logic [W-1:0] g;
    g = '0;
    if (e) begin
      for (int unsigned k = 1; k <= W; k++) begin
        int unsigned j;
        j = (li + k) % W;
        if (q[j] && g == '0) g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic step(input logic r, input logic e, input logic [W-1:0] q,
                      input logic [W-1:0] ex, input string nm);
    logic [W-1:0] want;
    @(posedge clk);
    #1;
    rst = r; enable = e; request = q;
    exp_q.push_back(ex);
    @(negedge clk);
    want = exp_q.pop_front();
    n_cmp++;
    if (grant !== want) begin
      n_err++;
      $display("FAIL %s: grant=%b expected=%b (rst=%b en=%b req=%b)", nm, grant, want, r, e, q);
    end
  endtask

  task automatic step1(input logic r, input logic e, input logic q, input logic ex,
                       input string nm);
    @(posedge clk);
    #1;
    rst1 = r; en1 = e; req1 = q;
    @(negedge clk);
    n_cmp++;
    if (grant1 !== ex) begin
      n_err++;
      $display("FAIL %s: grant=%b expected=%b", nm, grant1, ex);
    end
  endtask

  initial begin
    int unsigned mlast;
    logic [W-1:0] ex;
    logic r, e;
    logic [W-1:0] q;

    rst = 1'b1; enable = 1'b0; request = '0;
    rst1 = 1'b1; en1 = 1'b0; req1 = 1'b0;

    // reset, then full-request rotation
    add_vec(1, 0, 4'b1111, 4'b0000);
    add_vec(1, 0, 4'b1111, 4'b0000);
    add_vec(0, 1, 4'b1111, 4'b0001);
    add_vec(0, 1, 4'b1111, 4'b0010);
    add_vec(0, 1, 4'b1111, 4'b0100);
    add_vec(0, 1, 4'b1111, 4'b1000);
    add_vec(0, 1, 4'b1111, 4'b0001);
    add_vec(0, 1, 4'b1111, 4'b0010);
    add_vec(0, 1, 4'b1111, 4'b0100);
    // wrap-around skip
    add_vec(0, 1, 4'b0011, 4'b0001);
    add_vec(0, 1, 4'b0011, 4'b0010);
    // enable freeze
    add_vec(0, 0, 4'b1111, 4'b0000);
    add_vec(0, 0, 4'b1111, 4'b0000);
    add_vec(0, 0, 4'b1111, 4'b0000);
    add_vec(0, 1, 4'b1111, 4'b0100);
    // single requester, then sparse
    add_vec(0, 1, 4'b1000, 4'b1000);
    add_vec(0, 1, 4'b1000, 4'b1000);
    add_vec(0, 1, 4'b1000, 4'b1000);
    add_vec(0, 1, 4'b1001, 4'b0001);
    // zero request leaves pointer alone
    add_vec(0, 1, 4'b0000, 4'b0000);
    add_vec(0, 1, 4'b1111, 4'b0010);
    add_vec(0, 1, 4'b1111, 4'b0100);
    // mid-stream reset: grant still uses old pointer during the reset cycle
    add_vec(1, 1, 4'b1111, 4'b1000);
    add_vec(0, 1, 4'b1111, 4'b0001);
    // dropped / partial requests
    add_vec(0, 1, 4'b1100, 4'b0100);
    add_vec(0, 1, 4'b0010, 4'b0010);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Random run against the scanning model; pointer index is 1 after the table.
    mlast = 1;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      q = W'($urandom_range(0, (1 << W) - 1));
      ex = model_grant(mlast, e, q);
      step(r, e, q, ex, $sformatf("rand%0d", n));
      if (r) begin
        mlast = W - 1;
      end else if (e && ex != '0) begin
        for (int unsigned b = 0; b < W; b++) if (ex[b]) mlast = b;
      end
    end

    // Long fairness sequence from reset with everyone requesting.
    step(1, 1, 4'b1111, model_grant(mlast, 1'b1, 4'b1111), "fair_rst");
    for (int n = 0; n < 8; n++) begin
      ex = 4'b0001 << (n % W);
      step(0, 1, 4'b1111, ex, $sformatf("fair%0d", n));
    end

    // WIDTH=1 instance
    step1(1, 0, 1'b1, 1'b0, "w1_rst");
    step1(0, 1, 1'b1, 1'b1, "w1_grant");
    step1(0, 1, 1'b1, 1'b1, "w1_regrant");
    step1(0, 0, 1'b1, 1'b0, "w1_disabled");
    step1(0, 1, 1'b0, 1'b0, "w1_noreq");
    step1(0, 1, 1'b1, 1'b1, "w1_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
